pipe_stage_hs: RTL and testbench
================================

Name: pipe_stage_hs

Overview:
- Generic, parametrised pipeline stage register that replaces the hand-written per-stage registers, e.g. between ID and EX.
- Carries an opaque payload of WIDTH bits using a valid/ready handshake on both sides.
- Supports a synchronous flush and an optional 2-entry skid mode. In skid mode the upstream ready is fully registered, which breaks the combinational ready path across stages.
- Provides occupancy and stall-cycle observability for perf counters and difftest.

Parameters:
- WIDTH, 64: payload width in bits; must be >= 1.
- SKID, 0: 0 = single register, ready passes through combinationally; 1 = 2-entry skid buffer, ready registered.
- RESET_VAL, 0: payload value after reset. When CLR_ON_FLUSH=1, also the payload value after flush.
- CLR_ON_FLUSH, 1: 1 = payload registers are loaded with RESET_VAL on flush; 0 = payload is held and only the valids are cleared.
- CNT_W, 32: width of the stall counter.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_flush  in  1  kill all entries held in the stage.
- i_in_valid  in  1  upstream has a payload.
- o_in_ready  out  1  stage can accept this cycle.
- i_in_data  in  WIDTH  upstream payload.
- o_out_valid  out  1  stage presents a payload.
- i_out_ready  in  1  downstream accepts.
- o_out_data  out  WIDTH  presented payload.
- o_occ  out  2  entries held: 0, 1 or 2 (2 only when SKID=1).
- o_stall_cnt  out  CNT_W  count of cycles with o_out_valid=1 and i_out_ready=0.

Behaviour:
- Reset (i_rst_n=0 at a posedge):
  - o_out_valid=0, o_occ=0, o_stall_cnt=0.
  - All payload registers = RESET_VAL.
  - o_in_ready=1 on the first cycle after reset, in both modes.
  - Reset overrides flush and all handshakes.
- Handshakes:
  - Input accept when i_in_valid & o_in_ready.
  - Output transfer when o_out_valid & i_out_ready.
  - o_in_ready never depends on i_in_valid.
  - While o_out_valid=1 and i_out_ready=0, o_out_data is stable.
  - Payload registers are written only on accept or flush (no free-running load).
- SKID=0:
  - o_in_ready = ~o_out_valid | i_out_ready (combinational).
  - On accept, the register loads i_in_data and valid is set next cycle.
  - On transfer without accept, valid is cleared.
  - Latency: 1 cycle, full throughput.
- SKID=1: state machine over states EMPTY, ONE, FULL.
  - Main register feeds o_out_data; the skid register holds overflow.
  - o_in_ready = (state != FULL), taken from a flop.
  - EMPTY:
    - accept -> ONE (main <= in).
  - ONE:
    - accept & transfer -> ONE (main <= in).
    - accept & ~transfer -> FULL (skid <= in).
    - transfer & ~accept -> EMPTY.
  - FULL:
    - transfer -> ONE (main <= skid).
    - No accept is possible in FULL.
  - Order is preserved.
  - Latency: 1 cycle, full throughput while i_out_ready stays high.
- Flush:
  - Synchronous, with priority over every handshake in the same cycle.
  - The next state is EMPTY (or valid=0 for SKID=0) and o_occ=0.
  - An input presented in the flush cycle is dropped. The ready shown that cycle is not honoured; upstream must treat the flush as a kill.
  - The downstream transfer in the flush cycle still counts as taken by the consumer.
  - Payload registers = RESET_VAL if CLR_ON_FLUSH=1, otherwise held.
  - o_in_ready=1 on the cycle after the flush.
- Stall counter:
  - Increments on every cycle with o_out_valid & ~i_out_ready.
  - Wraps modulo 2^CNT_W.
  - Not cleared by flush; cleared only by reset.
- o_occ:
  - 0/1 in SKID=0.
  - 0/1/2 in SKID=1, equal to the state encoding (EMPTY/ONE/FULL).

Decomposition:
- Package pipe_pkg:
  - typedef enum logic [1:0] {PS_EMPTY=0, PS_ONE=1, PS_FULL=2} pipe_state_t.
  - Localparam defaults for WIDTH/CNT_W.
- Sub-module: none new.
  - Payload registers reuse the existing stl_reg (i_wen, RESET_VAL).
  - The mode is selected by a generate on SKID.
- Per-stage wrappers (ID/EX etc.) concatenate fields into i_in_data and apply bubble/flush field substitution outside this block.

Test Plan:
- SKID=0, WIDTH=8, i_out_ready=1, stream 0x01..0x05 one per cycle -> o_out_data 0x01..0x05 one cycle later; o_in_ready always 1; o_stall_cnt=0.
- SKID=1, load 0xA1, 0xA2 with i_out_ready=0:
  - Required: o_occ=2 and o_in_ready=0 on the following cycle; o_out_data stays 0xA1.
  - Then set i_out_ready=1: required output order 0xA1 then 0xA2; o_occ goes 2->1->0.
  - o_stall_cnt = number of stalled cycles (e.g. 3 for a 3-cycle hold).
- SKID=1, FULL state, i_flush=1 with i_in_valid=1 data 0xFF:
  - Required next cycle: o_out_valid=0, o_occ=0, o_in_ready=1.
  - o_out_data=RESET_VAL (0) with CLR_ON_FLUSH=1.
  - 0xFF never appears on the output.
- CLR_ON_FLUSH=0, SKID=0, hold 0x5A then flush -> o_out_valid=0 and o_out_data remains 0x5A.
- Reset mid-operation: FULL with o_stall_cnt=7, pulse i_rst_n=0 for one cycle -> o_out_valid=0, o_occ=0, o_stall_cnt=0, o_in_ready=1 next cycle.
- Randomised valid/ready (both modes) against a reference queue -> no loss, no duplication, order preserved; o_out_data stable while stalled.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and default widths for pipeline stage registers
package pipe_pkg;
  typedef enum logic [1:0] {PS_EMPTY = 2'd0, PS_ONE = 2'd1, PS_FULL = 2'd2} pipe_state_t;
  localparam int PIPE_WIDTH = 64;
  localparam int PIPE_CNT_W = 32;
endpackage

// File: rtl/stl_reg.sv
// stl_reg: write-enabled register with synchronous active-low reset to RESET_VAL
module stl_reg #(
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wen,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] data_q;
  always_ff @(posedge i_clk)
    if (!i_rst_n) data_q <= RESET_VAL;
    else if (i_wen) data_q <= i_d;
  assign o_q = data_q;
endmodule

// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs: valid/ready pipeline stage, single register or 2-entry skid with registered ready
module pipe_stage_hs import pipe_pkg::*; #(
  parameter int WIDTH = PIPE_WIDTH,
  parameter bit SKID = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit CLR_ON_FLUSH = 1'b1,
  parameter int CNT_W = PIPE_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_data,
  output logic [1:0]       o_occ,
  output logic [CNT_W-1:0] o_stall_cnt
);
  logic             clr;
  logic             main_wen;
  logic [WIDTH-1:0] main_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  assign clr = i_flush & CLR_ON_FLUSH;
  stl_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wen(main_wen), .i_d(main_d), .o_q(o_out_data)
  );
  if (!SKID) begin : g_reg
    logic valid_q, valid_d, accept;
    always_comb begin
      accept = i_in_valid & o_in_ready & ~i_flush;
      valid_d = i_flush ? 1'b0 : accept ? 1'b1 : valid_q & ~i_out_ready;
      main_wen = accept | clr;
      main_d = i_flush ? RESET_VAL : i_in_data;
    end
    always_ff @(posedge i_clk)
      if (!i_rst_n) valid_q <= 1'b0;
      else valid_q <= valid_d;
    assign o_in_ready = ~valid_q | i_out_ready;
    assign o_out_valid = valid_q;
    assign o_occ = {1'b0, valid_q};
  end else begin : g_skid
    pipe_state_t state_q, state_d;
    logic rdy_q, rdy_d, accept, xfer, skid_wen;
    logic [WIDTH-1:0] skid_q;
    always_comb begin
      accept = i_in_valid & rdy_q & ~i_flush;
      xfer = (state_q != PS_EMPTY) & i_out_ready;
      state_d = i_flush ? PS_EMPTY :
                state_q == PS_EMPTY ? (accept ? PS_ONE : PS_EMPTY) :
                state_q == PS_ONE ? (accept & ~xfer ? PS_FULL : xfer & ~accept ? PS_EMPTY : PS_ONE) :
                (xfer ? PS_ONE : PS_FULL);
      rdy_d = state_d != PS_FULL;
      // FULL drains the skid entry into main; a held flush must not disturb either entry
      main_wen = clr | (accept & (state_q == PS_EMPTY | xfer)) | (state_q == PS_FULL & xfer & ~i_flush);
      main_d = i_flush ? RESET_VAL : state_q == PS_FULL ? skid_q : i_in_data;
      skid_wen = clr | (accept & state_q == PS_ONE & ~xfer);
    end
    always_ff @(posedge i_clk)
      if (!i_rst_n) begin
        state_q <= PS_EMPTY;
        rdy_q <= 1'b1;
      end else begin
        state_q <= state_d;
        rdy_q <= rdy_d;
      end
    stl_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wen(skid_wen), .i_d(main_d), .o_q(skid_q)
    );
    assign o_in_ready = rdy_q;
    assign o_out_valid = state_q != PS_EMPTY;
    assign o_occ = state_q;
  end
  always_comb stall_d = stall_q + CNT_W'(o_out_valid & ~i_out_ready);
  always_ff @(posedge i_clk)
    if (!i_rst_n) stall_q <= '0;
    else stall_q <= stall_d;
  assign o_stall_cnt = stall_q;
endmodule

// File: tb/tb_pipe_stage_hs.sv
// tb_pipe_stage_hs: directed and reference-queue checks of pipe_stage_hs in both modes
module tb_pipe_stage_hs;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fl [3];
  logic iv [3];
  logic ordy [3];
  logic irdy [3];
  logic ovld [3];
  logic [7:0] idat [3];
  logic [7:0] odat [3];
  logic [1:0] occ [3];
  logic [31:0] stl [3];
  logic [7:0] mem [2][0:511];
  int hd [2];
  int tl [2];
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_stage_hs #(.WIDTH(8), .SKID(1'b0), .RESET_VAL(8'h00), .CLR_ON_FLUSH(1'b1), .CNT_W(32)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(fl[0]), .i_in_valid(iv[0]), .o_in_ready(irdy[0]),
    .i_in_data(idat[0]), .o_out_valid(ovld[0]), .i_out_ready(ordy[0]), .o_out_data(odat[0]),
    .o_occ(occ[0]), .o_stall_cnt(stl[0]));
  pipe_stage_hs #(.WIDTH(8), .SKID(1'b1), .RESET_VAL(8'h00), .CLR_ON_FLUSH(1'b1), .CNT_W(32)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(fl[1]), .i_in_valid(iv[1]), .o_in_ready(irdy[1]),
    .i_in_data(idat[1]), .o_out_valid(ovld[1]), .i_out_ready(ordy[1]), .o_out_data(odat[1]),
    .o_occ(occ[1]), .o_stall_cnt(stl[1]));
  pipe_stage_hs #(.WIDTH(8), .SKID(1'b0), .RESET_VAL(8'h00), .CLR_ON_FLUSH(1'b0), .CNT_W(32)) u2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(fl[2]), .i_in_valid(iv[2]), .o_in_ready(irdy[2]),
    .i_in_data(idat[2]), .o_out_valid(ovld[2]), .i_out_ready(ordy[2]), .o_out_data(odat[2]),
    .o_occ(occ[2]), .o_stall_cnt(stl[2]));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      fl[k] = 1'b0; iv[k] = 1'b0; ordy[k] = 1'b0; idat[k] = 8'h00;
    end
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_vld%0d", k), 64'(ovld[k]), 64'd0);
      chk($sformatf("rst_occ%0d", k), 64'(occ[k]), 64'd0);
      chk($sformatf("rst_stall%0d", k), 64'(stl[k]), 64'd0);
      chk($sformatf("rst_rdy%0d", k), 64'(irdy[k]), 64'd1);
      chk($sformatf("rst_data%0d", k), 64'(odat[k]), 64'd0);
    end
    // single-register stream at full throughput
    for (int i = 1; i <= 5; i++) begin
      iv[0] = 1'b1; idat[0] = 8'(i); ordy[0] = 1'b1;
      #1;
      chk("s0_rdy", 64'(irdy[0]), 64'd1);
      step();
      chk("s0_vld", 64'(ovld[0]), 64'd1);
      chk("s0_data", 64'(odat[0]), 64'(i));
    end
    iv[0] = 1'b0;
    step();
    chk("s0_drain", 64'(ovld[0]), 64'd0);
    chk("s0_stall", 64'(stl[0]), 64'd0);
    // skid: fill to FULL under backpressure, then drain in order
    iv[1] = 1'b1; idat[1] = 8'hA1; ordy[1] = 1'b0;
    step();
    chk("sk_occ1", 64'(occ[1]), 64'd1);
    chk("sk_a1", 64'(odat[1]), 64'hA1);
    idat[1] = 8'hA2;
    step();
    chk("sk_occ2", 64'(occ[1]), 64'd2);
    chk("sk_rdy_full", 64'(irdy[1]), 64'd0);
    chk("sk_hold_a1", 64'(odat[1]), 64'hA1);
    iv[1] = 1'b0;
    step();
    step();
    chk("sk_stall3", 64'(stl[1]), 64'd3);
    chk("sk_still_a1", 64'(odat[1]), 64'hA1);
    ordy[1] = 1'b1;
    #1;
    chk("sk_out_a1", 64'(odat[1]), 64'hA1);
    step();
    chk("sk_out_a2", 64'(odat[1]), 64'hA2);
    chk("sk_occ_1b", 64'(occ[1]), 64'd1);
    step();
    chk("sk_occ0", 64'(occ[1]), 64'd0);
    chk("sk_vld0", 64'(ovld[1]), 64'd0);
    chk("sk_stall_keep", 64'(stl[1]), 64'd3);
    // flush while FULL with a competing input
    ordy[1] = 1'b0; iv[1] = 1'b1; idat[1] = 8'hB1;
    step();
    idat[1] = 8'hB2;
    step();
    chk("fl_full", 64'(occ[1]), 64'd2);
    fl[1] = 1'b1; idat[1] = 8'hFF;
    step();
    fl[1] = 1'b0; iv[1] = 1'b0;
    #1;
    chk("fl_vld", 64'(ovld[1]), 64'd0);
    chk("fl_occ", 64'(occ[1]), 64'd0);
    chk("fl_rdy", 64'(irdy[1]), 64'd1);
    chk("fl_data", 64'(odat[1]), 64'd0);
    chk("fl_stall", 64'(stl[1]), 64'd5);
    ordy[1] = 1'b1;
    step();
    step();
    chk("fl_no_ff", 64'(odat[1]), 64'd0);
    chk("fl_still_empty", 64'(ovld[1]), 64'd0);
    // flush without payload clear keeps the data
    iv[2] = 1'b1; idat[2] = 8'h5A; ordy[2] = 1'b0;
    step();
    chk("nc_vld", 64'(ovld[2]), 64'd1);
    chk("nc_data", 64'(odat[2]), 64'h5A);
    iv[2] = 1'b0; fl[2] = 1'b1;
    step();
    fl[2] = 1'b0;
    #1;
    chk("nc_fl_vld", 64'(ovld[2]), 64'd0);
    chk("nc_fl_data", 64'(odat[2]), 64'h5A);
    chk("nc_fl_rdy", 64'(irdy[2]), 64'd1);
    // reset mid-operation from FULL
    ordy[1] = 1'b0; iv[1] = 1'b1; idat[1] = 8'hC1;
    step();
    idat[1] = 8'hC2;
    step();
    iv[1] = 1'b0;
    step();
    chk("mr_stall7", 64'(stl[1]), 64'd7);
    chk("mr_occ2", 64'(occ[1]), 64'd2);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mr_vld", 64'(ovld[1]), 64'd0);
    chk("mr_occ", 64'(occ[1]), 64'd0);
    chk("mr_stall", 64'(stl[1]), 64'd0);
    chk("mr_rdy", 64'(irdy[1]), 64'd1);
    chk("mr_data", 64'(odat[1]), 64'd0);
    // random valid/ready against a reference FIFO, both modes
    for (int k = 0; k < 2; k++) begin
      hd[k] = 0; tl[k] = 0;
    end
    for (int n = 0; n < 300; n++) begin
      for (int k = 0; k < 2; k++) begin
        iv[k] = 1'($urandom_range(0, 1));
        idat[k] = 8'($urandom);
        ordy[k] = $urandom_range(0, 3) != 0;
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("rnd_occ%0d", k), 64'(occ[k]), 64'(tl[k] - hd[k]));
        chk($sformatf("rnd_vld%0d", k), 64'(ovld[k]), 64'(tl[k] != hd[k]));
        if (tl[k] != hd[k]) chk($sformatf("rnd_data%0d", k), 64'(odat[k]), 64'(mem[k][hd[k]]));
        if (ovld[k] && ordy[k]) hd[k]++;
        if (iv[k] && irdy[k]) begin
          mem[k][tl[k]] = idat[k];
          tl[k]++;
        end
      end
      chk("rnd_rdy0", 64'(irdy[0]), 64'(!ovld[0] || ordy[0]));
      step();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
